// File: rtl/g711_expand_mc.sv
// Multi-channel G.711 expander: per-channel law register, 2-stage valid/ready pipeline.
// Optional two's-complement linear output port enabled by G711_LINEAR_OUT_EN.
module g711_expand_mc #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CH_W        = 2,
  parameter logic        DEFAULT_LAW = 1'b0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cfg_we,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic            cfg_law,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH_W-1:0] in_ch,
  input  logic [7:0]      in_pcm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH_W-1:0] out_ch,
  output logic            out_law,
  output logic [13:0]     out_mag
`ifdef G711_LINEAR_OUT_EN
  ,
  output logic [15:0]     out_lin
`endif
);

  localparam int unsigned MAG_W = 14;
  localparam int unsigned LIN_W = 16;

  logic [NUM_CH-1:0] law_q, law_d;

  logic            v1_q, v1_d;
  logic [CH_W-1:0] ch1_q, ch1_d;
  logic [7:0]      pcm1_q, pcm1_d;
  logic            law1_q, law1_d;

  logic             v2_q, v2_d;
  logic [CH_W-1:0]  ch2_q, ch2_d;
  logic             law2_q, law2_d;
  logic [MAG_W-1:0] mag2_q, mag2_d;
`ifdef G711_LINEAR_OUT_EN
  logic [LIN_W-1:0] lin2_q, lin2_d;
`endif

  logic adv1_c, adv2_c, accept_c;
  logic law_in_c;

  logic [7:0]       p_c;
  logic [3:0]       q_c;
  logic [2:0]       s_c;
  logic             sg_c;
  logic [MAG_W-1:0] base_c;
  logic [MAG_W-1:0] u_sh_c;
  logic [12:0]      u_m_c;
  logic [MAG_W-1:0] a_bias_c;
  logic [MAG_W-1:0] a_a_c;
  logic [11:0]      a_m_c;
  logic [MAG_W-1:0] mag_c;
  logic [LIN_W-1:0] lin_mag_c;
  logic             lin_neg_c;
  logic [LIN_W-1:0] lin_c;

  // Handshake: a stage advances when it is empty or its consumer advances
  always_comb begin
    adv2_c   = !v2_q || out_ready;
    adv1_c   = !v1_q || adv2_c;
    accept_c = in_valid && adv1_c;
  end

  assign in_ready = adv1_c;

  // Law lookup and config update; out-of-range channels use the reset law
  always_comb begin
    law_in_c = DEFAULT_LAW;
    law_d    = law_q;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (in_ch == CH_W'(i)) begin
        law_in_c = law_q[i];
      end
      if (cfg_we && (cfg_ch == CH_W'(i))) begin
        law_d[i] = cfg_law;
      end
    end
  end

  // Expansion of the stage-1 codeword
  always_comb begin
    p_c      = law1_q ? (pcm1_q ^ 8'h55) : ~pcm1_q;
    q_c      = p_c[3:0];
    s_c      = p_c[6:4];
    sg_c     = p_c[7];
    base_c   = {9'd0, q_c, 1'b0};

    u_sh_c   = (base_c + 14'd33) << s_c;
    u_m_c    = 13'(u_sh_c - 14'd33);

    a_bias_c = (s_c != 3'd0) ? 14'd33 : 14'd1;
    a_a_c    = base_c + a_bias_c;
    a_m_c    = (s_c > 3'd1) ? 12'(a_a_c << (s_c - 3'd1)) : 12'(a_a_c);

    if (law1_q) begin
      mag_c     = {1'b0, ~sg_c, a_m_c};
      lin_mag_c = {1'b0, a_m_c, 3'b000};
      lin_neg_c = ~sg_c;
    end else begin
      mag_c     = {sg_c, u_m_c};
      lin_mag_c = {1'b0, u_m_c, 2'b00};
      lin_neg_c = sg_c;
    end
    lin_c = lin_neg_c ? (~lin_mag_c + 16'd1) : lin_mag_c;
  end

  // Next-state for both pipeline stages; stalled stages hold
  always_comb begin
    v1_d   = v1_q;
    ch1_d  = ch1_q;
    pcm1_d = pcm1_q;
    law1_d = law1_q;
    v2_d   = v2_q;
    ch2_d  = ch2_q;
    law2_d = law2_q;
    mag2_d = mag2_q;
`ifdef G711_LINEAR_OUT_EN
    lin2_d = lin2_q;
`endif

    if (adv1_c) begin
      v1_d = accept_c;
    end
    if (accept_c) begin
      ch1_d  = in_ch;
      pcm1_d = in_pcm;
      law1_d = law_in_c;
    end

    if (adv2_c) begin
      v2_d = v1_q;
    end
    if (adv2_c && v1_q) begin
      ch2_d  = ch1_q;
      law2_d = law1_q;
      mag2_d = mag_c;
`ifdef G711_LINEAR_OUT_EN
      lin2_d = lin_c;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      law_q  <= {NUM_CH{DEFAULT_LAW}};
      v1_q   <= 1'b0;
      ch1_q  <= '0;
      pcm1_q <= '0;
      law1_q <= 1'b0;
      v2_q   <= 1'b0;
      ch2_q  <= '0;
      law2_q <= 1'b0;
      mag2_q <= '0;
`ifdef G711_LINEAR_OUT_EN
      lin2_q <= '0;
`endif
    end else begin
      law_q  <= law_d;
      v1_q   <= v1_d;
      ch1_q  <= ch1_d;
      pcm1_q <= pcm1_d;
      law1_q <= law1_d;
      v2_q   <= v2_d;
      ch2_q  <= ch2_d;
      law2_q <= law2_d;
      mag2_q <= mag2_d;
`ifdef G711_LINEAR_OUT_EN
      lin2_q <= lin2_d;
`endif
    end
  end

  assign out_valid = v2_q;
  assign out_ch    = ch2_q;
  assign out_law   = law2_q;
  assign out_mag   = mag2_q;
`ifdef G711_LINEAR_OUT_EN
  assign out_lin   = lin2_q;
`else
  // Linear result only feeds the optional port
  logic unused_lin_c;
  assign unused_lin_c = ^lin_c;
`endif

endmodule

// File: tb/tb_g711_expand_mc.sv
// Scoreboard bench for g711_expand_mc: randomized traffic against an arithmetic reference model.
module tb_g711_expand_mc;

  localparam int unsigned NUM_CH  = 3;
  localparam int unsigned CH_W    = 2;
  localparam bit          DEF_LAW = 1'b0;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            cfg_we = 1'b0;
  logic [CH_W-1:0] cfg_ch = '0;
  logic            cfg_law = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [CH_W-1:0] in_ch = '0;
  logic [7:0]      in_pcm = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [CH_W-1:0] out_ch;
  logic            out_law;
  logic [13:0]     out_mag;
`ifdef G711_LINEAR_OUT_EN
  logic [15:0]     out_lin;
`endif

  g711_expand_mc #(.NUM_CH(NUM_CH), .CH_W(CH_W), .DEFAULT_LAW(DEF_LAW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_law(cfg_law),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_pcm(in_pcm),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_law(out_law), .out_mag(out_mag)
`ifdef G711_LINEAR_OUT_EN
    , .out_lin(out_lin)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH_W-1:0] ch;
    bit              law;
    logic [13:0]     mag;
    logic [15:0]     lin;
  } exp_t;

  exp_t sb[$];
  bit   law_m[NUM_CH];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference expansion straight from the G.711 arithmetic rules
  function automatic exp_t model(input logic [CH_W-1:0] ch, input bit law, input logic [7:0] pcm);
    exp_t e;
    int p, q, s, sg, m, lin;
    p  = law ? (int'(pcm) ^ 'h55) : (255 - int'(pcm));
    q  = p % 16;
    s  = (p / 16) % 8;
    sg = p / 128;
    if (!law) begin
      m     = (2 * q + 33) * (1 << s) - 33;
      e.mag = 14'(sg * 8192 + m);
      lin   = (sg != 0) ? -(m * 4) : m * 4;
    end else begin
      m = 2 * q + ((s != 0) ? 33 : 1);
      if (s > 1) m = m * (1 << (s - 1));
      e.mag = 14'(((sg != 0) ? 0 : 4096) + m);
      lin   = (sg != 0) ? m * 8 : -(m * 8);
    end
    e.ch  = ch;
    e.law = law;
    e.lin = 16'(lin);
    return e;
  endfunction

  function automatic bit law_of(input logic [CH_W-1:0] ch);
    if (int'(ch) < int'(NUM_CH)) return law_m[int'(ch)];
    return DEF_LAW;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle of stimulus; returns whether the sample was accepted
  task automatic drive(input bit v, input logic [CH_W-1:0] ch, input logic [7:0] pcm,
                       input bit ordy, input bit cw, input logic [CH_W-1:0] cch,
                       input bit claw, output bit acc);
    @(negedge clk);
    in_valid  = v;
    in_ch     = ch;
    in_pcm    = pcm;
    out_ready = ordy;
    cfg_we    = cw;
    cfg_ch    = cch;
    cfg_law   = claw;
    #1;
    acc = v && in_ready;
    if (acc) sb.push_back(model(ch, law_of(ch), pcm));
    if (cw && int'(cch) < int'(NUM_CH)) law_m[int'(cch)] = claw;
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    drive(1'b0, '0, 8'h00, ordy, 1'b0, '0, 1'b0, acc);
  endtask

  task automatic send(input logic [CH_W-1:0] ch, input logic [7:0] pcm, input bit ordy);
    bit acc;
    int t;
    t = 0;
    do begin
      drive(1'b1, ch, pcm, ordy, 1'b0, '0, 1'b0, acc);
      t++;
    end while (!acc && t < 50);
    chk("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sb.size() != 0; t++) idle(1'b1);
    idle(1'b1);
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every presented output is compared with the scoreboard head
  initial begin
    exp_t e;
    bit   bad;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && out_valid) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output: got ch=%0d mag=%h expected no output", out_ch, out_mag);
        end else begin
          e   = sb[0];
          bad = (out_ch !== e.ch) || (out_law !== e.law) || (out_mag !== e.mag);
`ifdef G711_LINEAR_OUT_EN
          bad = bad || (out_lin !== e.lin);
`endif
          if (bad) begin
            n_err++;
            $display("FAIL out_sample: got ch=%0d law=%0d mag=%h expected ch=%0d law=%0d mag=%h lin=%h",
                     out_ch, out_law, out_mag, e.ch, e.law, e.mag, e.lin);
          end
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    bit              acc;
    int              idx;
    bit              pv;
    logic [CH_W-1:0] pch;
    logic [7:0]      ppcm;

    foreach (law_m[i]) law_m[i] = DEF_LAW;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_mag", 32'(out_mag), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_out_law", 32'(out_law), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // u-law extremes and 2-cycle latency
    drive(1'b1, 2'd0, 8'hFF, 1'b1, 1'b0, '0, 1'b0, acc);
    chk("lat_accept", 32'(acc), 32'd1);
    idle(1'b1);
    chk("lat_cycle1", 32'(out_valid), 32'd0);
    idle(1'b1);
    chk("lat_cycle2", 32'(out_valid), 32'd1);
    send(2'd0, 8'h00, 1'b1);

    // A-law on ch1
    drive(1'b0, '0, 8'h00, 1'b1, 1'b1, 2'd1, 1'b1, acc);
    send(2'd1, 8'hD5, 1'b1);
    send(2'd1, 8'h55, 1'b1);
    send(2'd1, 8'h2A, 1'b1);
    drain();

    // Back-to-back stream with a 5-cycle output stall at the start
    idx = 0;
    for (int c = 0; c < 60 && idx < 8; c++) begin
      drive(1'b1, CH_W'(idx % 4), 8'(idx * 37 + 5), (c >= 5), 1'b0, '0, 1'b0, acc);
      if (acc) idx++;
      if (c == 4) begin
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_accepts", 32'(idx), 32'd2);
      end
    end
    chk("stream_count", 32'(idx), 32'd8);
    drain();

    // Same-cycle config write and sample on ch2: old law applies
    drive(1'b1, 2'd2, 8'hD5, 1'b1, 1'b1, 2'd2, 1'b1, acc);
    chk("samecyc_accept", 32'(acc), 32'd1);
    send(2'd2, 8'hD5, 1'b1);
    send(2'd3, 8'h2A, 1'b1);
    drain();

    // Reset with two samples in flight and output stalled
    send(2'd0, 8'h12, 1'b0);
    send(2'd1, 8'h34, 1'b0);
    idle(1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    sb.delete();
    foreach (law_m[i]) law_m[i] = DEF_LAW;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) idle(1'b1);
    send(2'd1, 8'h55, 1'b1);
    send(2'd2, 8'h00, 1'b1);
    drain();

    // Randomized traffic with config writes and backpressure
    pv   = 1'b0;
    pch  = '0;
    ppcm = '0;
    for (int c = 0; c < 600; c++) begin
      if (!pv && ($urandom % 4 != 0)) begin
        pv   = 1'b1;
        pch  = CH_W'($urandom % 4);
        ppcm = 8'($urandom);
      end
      drive(pv, pch, ppcm, ($urandom % 4 != 0), ($urandom % 6 == 0),
            CH_W'($urandom % 4), 1'($urandom % 2), acc);
      if (acc) pv = 1'b0;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
